// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, issues word fetches over req/gnt/rvalid,
// tags returns with their PC in an in-order queue and buffers them in a small
// FIFO for decode. Branch/jump redirects flush the buffer and drop the
// responses of any requests still in flight.
// Optional build macro: FETCH_MISALIGN_CHECK_EN adds the sticky fetch_misalign
// output and a FAULT state that halts fetch after a misaligned redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {BOOT, FETCH, HOLD, FAULT} state_e;
`else
  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_e;
`endif

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [TW-1:0] trptr_q, trptr_d, twptr_q, twptr_d;

  fetch_entry_t  fifo_mem [FIFO_DEPTH];
  logic [31:0]   tag_mem  [MAX_OUTSTANDING];

  logic gnt_ok, rv_ok, push, pop, redir, credit_ok, misalign_redir;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
  endfunction

  // Credit counts buffered entries plus every in-flight request (dropped
  // ones included), so a returning response always finds a free slot.
  assign credit_ok = (32'(cnt_q) + 32'(out_q)) < 32'(FIFO_DEPTH);
  assign imem_req  = (state_q == FETCH) && credit_ok && (out_q < OW'(MAX_OUTSTANDING));
  assign imem_addr = pc_q;

  assign instr_valid = (cnt_q != '0);
  assign instr_data  = instr_valid ? fifo_mem[rptr_q].data : '0;
  assign instr_pc    = instr_valid ? fifo_mem[rptr_q].pc   : '0;

  assign gnt_ok = imem_req && imem_gnt;
  // A response with nothing in flight is a protocol error and is ignored.
  assign rv_ok  = imem_rvalid && (out_q != '0);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign redir          = redirect_valid && (state_q != FAULT);
  assign misalign_redir = redir && (redirect_pc[1:0] != 2'b00);
  assign fetch_misalign = misalign_q;
`else
  assign redir          = redirect_valid;
  assign misalign_redir = 1'b0;
`endif

  // Redirect wins: nothing from the flushed path is pushed or popped that cycle.
  assign push = rv_ok && (drop_q == '0) && !redir;
  assign pop  = instr_valid && instr_ready && !redir;

  // Next-state logic: BOOT lasts one cycle, FETCH/HOLD follow credit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (!credit_ok) state_d = HOLD;
      HOLD:    if (credit_ok)  state_d = FETCH;
      default: state_d = state_q;
    endcase
    if (redir) state_d = FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
    if (misalign_redir) state_d = FAULT;
`endif
  end

  // Datapath next values: pc, in-flight/drop counters, tag queue, FIFO pointers.
  always_comb begin
    pc_d    = pc_q;
    out_d   = out_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    trptr_d = trptr_q;
    twptr_d = twptr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d = misalign_q | misalign_redir;
`endif
    // The tag queue is never flushed: dropped responses still consume tags.
    if (gnt_ok) twptr_d = tag_inc(twptr_q);
    if (rv_ok)  trptr_d = tag_inc(trptr_q);
    out_d = out_q + OW'(gnt_ok) - OW'(rv_ok);
    if (gnt_ok) pc_d = pc_q + 32'd4;
    if (rv_ok && (drop_q != '0)) drop_d = drop_q - OW'(1);
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (redir) begin
      pc_d   = redirect_pc & 32'hFFFF_FFFC;
      cnt_d  = '0;
      rptr_d = '0;
      wptr_d = '0;
      // Everything still in flight after this edge belongs to the old path.
      // Only an accepted response is subtracted, so this cannot underflow.
      drop_d = out_q + OW'(gnt_ok) - OW'(rv_ok);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
      cnt_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      trptr_q <= '0;
      twptr_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      trptr_q <= trptr_d;
      twptr_q <= twptr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Storage arrays: contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (push)   fifo_mem[wptr_q] <= '{pc: tag_mem[trptr_q], data: imem_rdata};
    if (gnt_ok) tag_mem[twptr_q] <= pc_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: bench acts as instruction memory (data = addr ^ KEY,
// in-order returns) and as decode. The reference model is the program-order
// stream: grants and deliveries must walk +4 from the last redirect target.
module tb_instr_fetch_unit;
  localparam logic [31:0] KEY     = 32'hA5A5_0000;
  localparam int          MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int cyc; } pend_t;

  int checks = 0, failures = 0, cyc = 0, ngrants = 0;
  int gnt_pct = 0, rv_pct = 0, rdy_pct = 0;
  logic redir_go = 1'b0, redir_eff = 1'b1;
  logic [31:0] redir_tgt = 32'h0;
  logic [31:0] exp_fetch, exp_pc;
  logic chk_after_redir = 1'b0, prev_wait = 1'b0;
  logic [31:0] redir_exp, prev_addr;
  pend_t pending[$];
  logic [31:0] glog[$], dlog[$];
  int gclog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gl(input int i);
    return (glog.size() > i) ? glog[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] dl(input int i);
    return (dlog.size() > i) ? dlog[i] : 32'hxxxx_xxxx;
  endfunction

  // One cycle: sample outputs at negedge, check, drive inputs, advance model.
  task automatic tick();
    logic s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_data;
    @(negedge clk);
    cyc++;
    s_req = imem_req; s_addr = imem_addr;
    s_valid = instr_valid; s_pc = instr_pc; s_data = instr_data;
    if (chk_after_redir) begin
      chk("redir_addr", s_addr, redir_exp);
      chk("redir_flush", 32'(s_valid), 32'd0);
      chk_after_redir = 1'b0;
    end
    if (prev_wait) begin
      chk("req_hold", 32'(s_req), 32'd1);
      chk("addr_hold", s_addr, prev_addr);
    end
    if (s_req) chk("addr_align", s_addr & 32'h3, 32'd0);
    imem_gnt = ($urandom_range(0, 99) < gnt_pct);
    if (pending.size() > 0 && pending[0].cyc < cyc && $urandom_range(0, 99) < rv_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pending[0].addr ^ KEY;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    instr_ready    = ($urandom_range(0, 99) < rdy_pct);
    redirect_valid = redir_go;
    redirect_pc    = redir_tgt;
    redir_go       = 1'b0;
    if (s_req && imem_gnt) begin
      chk("grant_addr", s_addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      pending.push_back('{addr: s_addr, cyc: cyc});
      glog.push_back(s_addr);
      gclog.push_back(cyc);
      ngrants++;
    end
    if (imem_rvalid) void'(pending.pop_front());
    chk("outstanding_bound", 32'(pending.size() <= MAX_OUT), 32'd1);
    if (s_valid && instr_ready && !(redirect_valid && redir_eff)) begin
      chk("deliver_pc", s_pc, exp_pc);
      chk("deliver_data", s_data, exp_pc ^ KEY);
      exp_pc = exp_pc + 32'd4;
      dlog.push_back(s_pc);
    end
    prev_wait = s_req && !imem_gnt && !(redirect_valid && redir_eff);
    prev_addr = s_addr;
    if (redirect_valid && redir_eff) begin
      exp_fetch = redirect_pc & 32'hFFFF_FFFC;
      exp_pc    = exp_fetch;
      redir_exp = exp_fetch;
      chk_after_redir = 1'b1;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic knobs(input int g, input int r, input int d);
    gnt_pct = g; rv_pct = r; rdy_pct = d;
  endtask

  // Asynchronous reset pulse in mid-cycle; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0000);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_data", instr_data, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; instr_ready = 0;
    redirect_valid = 0; redirect_pc = 0;
    pending.delete(); glog.delete(); dlog.delete(); gclog.delete();
    exp_fetch = 32'h0; exp_pc = 32'h0;
    prev_wait = 0; chk_after_redir = 0; redir_eff = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    redir_go = 1'b1; redir_tgt = tgt;
    tick();
  endtask

  initial begin
    int frv, fv, gaps, g0, n10;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; instr_ready = 0;
    redirect_valid = 0; redirect_pc = 0;
    exp_fetch = 0; exp_pc = 0;
    do_reset();

    // Streaming: full grant, 1-cycle memory, decode always ready.
    knobs(100, 100, 100);
    frv = -1; fv = -1; gaps = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (imem_rvalid && frv < 0) frv = cyc;
      if (instr_valid && fv < 0) fv = cyc;
      else if (fv >= 0 && !instr_valid) gaps++;
    end
    chk("stream_a0", gl(0), 32'h0);
    chk("stream_a1", gl(1), 32'h4);
    chk("stream_a2", gl(2), 32'h8);
    chk("stream_a3", gl(3), 32'hC);
    chk("stream_consec", 32'(gclog.size() >= 4 && gclog[3] - gclog[0] == 3), 32'd1);
    chk("push_to_valid", 32'(fv - frv), 32'd1);
    chk("valid_sustained", 32'(gaps), 32'd0);

    // Backpressure: from empty, exactly FIFO_DEPTH grants, then HOLD.
    knobs(0, 100, 100); ticks(8);
    knobs(100, 100, 0);
    g0 = ngrants; ticks(20);
    chk("hold_grants", 32'(ngrants - g0), 32'd4);
    chk("hold_req", 32'(imem_req), 32'd0);
    knobs(100, 100, 100); g0 = ngrants; tick();
    knobs(100, 100, 0); ticks(10);
    chk("one_pop_one_req", 32'(ngrants - g0), 32'd1);

    // Redirect with 8 and C outstanding.
    do_reset();
    knobs(100, 0, 100);
    g0 = ngrants;
    for (int i = 0; i < 10 && ngrants - g0 < 2; i++) tick();
    knobs(0, 100, 100); ticks(4);
    knobs(100, 0, 100);
    g0 = ngrants;
    for (int i = 0; i < 10 && ngrants - g0 < 2; i++) tick();
    chk("two_out_a", gl(2), 32'h8);
    chk("two_out_b", gl(3), 32'hC);
    knobs(0, 0, 100);
    glog.delete(); dlog.delete();
    redirect_to(32'h0000_0100);
    knobs(100, 100, 100); ticks(15);
    chk("redir_first_req", gl(0), 32'h100);
    chk("redir_first_pc", dl(0), 32'h100);

    // Redirect in the same cycle as the grant for 0x10 and an rvalid.
    knobs(0, 100, 100); ticks(6);
    redirect_to(32'h0000_000C);
    glog.delete();
    knobs(100, 0, 100); tick();
    knobs(100, 100, 100);
    redir_go = 1'b1; redir_tgt = 32'h0000_0200;
    tick();
    chk("gnt_redir_a", gl(0), 32'hC);
    chk("gnt_redir_b", gl(1), 32'h10);
    glog.delete(); dlog.delete();
    ticks(15);
    chk("gnt_redir_req", gl(0), 32'h200);
    chk("gnt_redir_pc", dl(0), 32'h200);
    n10 = 0;
    foreach (dlog[i]) if (dlog[i] == 32'h10 || dlog[i] == 32'hC) n10++;
    chk("no_wrong_path", 32'(n10), 32'd0);

    // PC wrap at the top of the address space.
    knobs(0, 100, 100); ticks(6);
    redirect_to(32'hFFFF_FFF8);
    glog.delete();
    knobs(100, 100, 100); ticks(10);
    chk("wrap_a", gl(0), 32'hFFFF_FFF8);
    chk("wrap_b", gl(1), 32'hFFFF_FFFC);
    chk("wrap_c", gl(2), 32'h0000_0000);

    // Misaligned redirect.
    knobs(0, 100, 100); ticks(6);
    glog.delete(); dlog.delete();
    redirect_to(32'h0000_0102);
    knobs(100, 100, 100);
`ifdef FETCH_MISALIGN_CHECK_EN
    tick();
    chk("misalign_set", 32'(fetch_misalign), 32'd1);
    g0 = ngrants; ticks(10);
    redir_eff = 1'b0;
    redirect_to(32'h0000_0040);
    ticks(10);
    chk("fault_no_grants", 32'(ngrants - g0), 32'd0);
    chk("fault_req", 32'(imem_req), 32'd0);
    chk("misalign_sticky", 32'(fetch_misalign), 32'd1);
    do_reset();
    knobs(100, 100, 100); ticks(10);
    chk("fault_cleared_fetch", gl(0), 32'h0);
`else
    ticks(15);
    chk("misalign_req", gl(0), 32'h100);
    chk("misalign_pc", dl(0), 32'h100);
`endif

    // Randomized traffic with random redirects against the program-order model.
    dlog.delete();
    knobs(60, 50, 60);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        redir_go = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
        redir_tgt = $urandom & 32'h0000_FFFC;
`else
        redir_tgt = $urandom & 32'h0000_FFFF;
`endif
      end
      tick();
    end
    chk("random_progress", 32'(dlog.size() > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
